// File: rtl/sparse_pkg.sv
// Shared constants and state encoding for the sparse weight packer and the MAC row.
package sparse_pkg;

  localparam int unsigned NZ    = 8;
  localparam int unsigned BW    = 4;
  localparam int unsigned COL   = 4;
  localparam int unsigned IDX_W = $clog2(COL);

  // Packer FSM: accumulate nonzeros in FILL, hold a finished word in EMIT.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } pack_state_e;

endpackage

// File: rtl/sparse_compact.sv
// Combinational compaction: appends the nonzero elements of one dense vector to the slot
// buffer at slot count_i, in ascending position order, and returns the updated count.
module sparse_compact
  import sparse_pkg::*;
#(
  parameter int unsigned nz  = NZ,
  parameter int unsigned bw  = BW,
  parameter int unsigned col = COL,
  parameter int unsigned iw  = (COL > 1) ? $clog2(COL) : 1,
  parameter int unsigned cw  = $clog2(NZ + 1)
) (
  input  logic [col-1:0][bw-1:0] weight_i,
  input  logic [cw-1:0]          count_i,
  input  logic [nz-1:0][bw-1:0]  slot_w_i,
  input  logic [nz-1:0][iw-1:0]  slot_idx_i,
  output logic [nz-1:0][bw-1:0]  slot_w_o,
  output logic [nz-1:0][iw-1:0]  slot_idx_o,
  output logic [cw-1:0]          new_count_o
);

  logic [col-1:0]         nz_mask;
  logic [col-1:0][cw-1:0] slot_of;
  logic [cw-1:0]          acc;

  // Prefix popcount: each position's destination slot is count_i plus the number of
  // nonzero positions below it.
  always_comb begin
    acc = count_i;
    for (int p = 0; p < int'(col); p++) begin
      nz_mask[p] = |weight_i[p];
      slot_of[p] = acc;
      acc        = acc + cw'(nz_mask[p]);
    end
    new_count_o = acc;
  end

  // Slot mapping: a slot takes the nonzero element whose destination matches it; slots
  // not hit keep their previous contents.
  always_comb begin
    slot_w_o   = slot_w_i;
    slot_idx_o = slot_idx_i;
    for (int s = 0; s < int'(nz); s++) begin
      for (int p = 0; p < int'(col); p++) begin
        if (nz_mask[p] && (slot_of[p] == cw'(s))) begin
          slot_w_o[s]   = weight_i[p];
          slot_idx_o[s] = iw'(p);
        end
      end
    end
  end

endmodule

// File: rtl/sparse_weight_packer.sv
// Packs nonzero weights of dense input vectors into fixed-width words of nz slots, each
// slot carrying the weight and its column index, for the MAC row load path.
module sparse_weight_packer
  import sparse_pkg::*;
#(
  parameter int unsigned nz  = NZ,
  parameter int unsigned bw  = BW,
  parameter int unsigned col = COL,
  localparam int unsigned iw = (col > 1) ? $clog2(col) : 1,
  localparam int unsigned cw = $clog2(nz + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [col*bw-1:0] in_weight_flat,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [nz*bw-1:0]  nzero_weights_flat,
  output logic [nz*iw-1:0]  w_indexes_flat,
  output logic [cw-1:0]     out_count,
  output logic              out_last
);

  // Once count exceeds this, another full vector of nonzeros might not fit.
  localparam int Thresh = int'(nz) - int'(col);

  pack_state_e           state_q, state_d;
  logic [cw-1:0]         count_q, count_d;
  logic [nz-1:0][bw-1:0] slot_w_q, slot_w_d;
  logic [nz-1:0][iw-1:0] slot_idx_q, slot_idx_d;
  logic [cw-1:0]         out_count_q, out_count_d;
  logic                  out_last_q, out_last_d;

  logic [nz-1:0][bw-1:0] cmp_w;
  logic [nz-1:0][iw-1:0] cmp_idx;
  logic [cw-1:0]         new_count;
  logic                  in_fire;
  logic                  out_fire;

  sparse_compact #(
    .nz (nz),
    .bw (bw),
    .col(col),
    .iw (iw),
    .cw (cw)
  ) u_compact (
    .weight_i   (in_weight_flat),
    .count_i    (count_q),
    .slot_w_i   (slot_w_q),
    .slot_idx_i (slot_idx_q),
    .slot_w_o   (cmp_w),
    .slot_idx_o (cmp_idx),
    .new_count_o(new_count)
  );

  assign in_ready  = (state_q == FILL) && !reset;
  assign out_valid = (state_q == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Slots beyond count are always zero because the buffer is cleared on every emission.
  assign nzero_weights_flat = slot_w_q;
  assign w_indexes_flat     = slot_idx_q;
  assign out_count          = out_count_q;
  assign out_last           = out_last_q;

  // Next-state: absorb vectors in FILL, hold the word in EMIT until it is taken.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    slot_w_d    = slot_w_q;
    slot_idx_d  = slot_idx_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          slot_w_d   = cmp_w;
          slot_idx_d = cmp_idx;
          count_d    = new_count;
          if ((int'(new_count) > Thresh) || in_last) begin
            state_d     = EMIT;
            out_count_d = new_count;
            out_last_d  = in_last;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          state_d     = FILL;
          count_d     = '0;
          slot_w_d    = '0;
          slot_idx_d  = '0;
          out_count_d = '0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State registers; synchronous reset drops any pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      slot_w_q    <= '0;
      slot_idx_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      slot_w_q    <= slot_w_d;
      slot_idx_q  <= slot_idx_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: doc/sparse_weight_packer.md
SPARSE_WEIGHT_PACKER -- requirements
Module: sparse_weight_packer

Interface
REQ-001 Parameter nz, default 8, number of packed output slots per word.
REQ-002 Parameter bw, default 4, weight width in bits.
REQ-003 Parameter col, default 4, dense weights per input vector; index width = clog2(col), 2 at default.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  dense vector present.
REQ-007 in_ready  output  1  packer accepts the vector this cycle.
REQ-008 in_weight_flat  input  col*bw  dense vector; position p at bits [p*bw +: bw].
REQ-009 in_last  input  1  vector ends a weight block; forces emission after absorb.
REQ-010 out_valid  output  1  packed word present.
REQ-011 out_ready  input  1  consumer (MAC row load path) takes the word.
REQ-012 nzero_weights_flat  output  nz*bw  packed nonzero weights; slot s at bits [s*bw +: bw].
REQ-013 w_indexes_flat  output  nz*2  column index per slot; slot s at bits [s*2 +: 2].
REQ-014 out_count  output  4  number of valid slots in word (0..nz).
REQ-015 out_last  output  1  word closes a weight block.

Function
REQ-016 Nonzero test SHALL be any bit set in the bw-bit field; values are raw bits, no sign interpretation.
REQ-017 Handshake: transfer occurs when valid and ready are both high in the same cycle, on both ports.
REQ-018 FSM states SHALL be FILL and EMIT; in_ready = (state==FILL) and not reset; out_valid = (state==EMIT).
REQ-019 On input transfer, the nonzero elements SHALL be appended to the slot buffer starting at slot count, in ascending position order, each slot storing weight and index = position p.
REQ-020 Packing: new_count = count + popcount(nonzero); the nz-col+1 guard (REQ-021) guarantees new_count <= nz.
REQ-021 After a transfer, FILL->EMIT when new_count > nz-col or in_last=1; otherwise remain in FILL with count = new_count.
REQ-022 Entering EMIT SHALL register out_count = new_count and out_last = in_last; the word is visible the cycle after the triggering transfer (latency 1).
REQ-023 Unused slots (s >= out_count) SHALL present weight 0 and index 0.
REQ-024 In EMIT, outputs SHALL hold stable until out_ready; on the output transfer, buffer cleared, count 0, state FILL.
REQ-025 All-zero vector with in_last=1 SHALL still emit a word (count may be 0) with out_last=1.
REQ-026 All-zero vector with in_last=0 SHALL leave buffer and count unchanged.
REQ-027 No input is accepted in the EMIT cycle, including the output-transfer cycle; the next acceptance occurs one cycle later.

Reset
REQ-028 Reset SHALL clear state to FILL, count to 0, all slots to 0, out_valid 0, out_count 0, out_last 0; in_ready 0 while reset is high.
REQ-029 Reset during EMIT SHALL discard the pending word with no handshake; reset overrides any simultaneous transfer.

Structure
REQ-030 Shared package sparse_pkg SHALL hold NZ, BW, COL, IDX_W constants and the FILL/EMIT state encoding, shared with the MAC row.
REQ-031 Combinational compaction (prefix popcount, slot mapping) SHALL live in one sub-module, sparse_compact.

Verification
REQ-032 Vectors 16'h3050, 16'h0708, 16'h1111 (in_last=0) -> after third: weights 5,3,8,7,1,1,1,1; indexes 1,3,0,2,0,1,2,3; out_count 8; out_last 0.
REQ-033 Empty buffer, 16'h0000 with in_last=1 -> word with out_count 0, all slots 0, out_last 1.
REQ-034 16'h000F with in_last=1 -> slot0 weight F, index 0; slots 1-7 zero; out_count 1; out_last 1.
REQ-035 out_ready low for 5 cycles during EMIT -> out_valid and data stable, in_ready 0; released -> FILL next cycle, count 0.
REQ-036 Reset asserted while out_valid=1 -> out_valid 0 next cycle, count 0, no stale word after release.
